// File: rtl/xeng_vacc_pkg.sv
// xeng_vacc_pkg
//    Shared constants for the X-engine vector accumulator.
//    - FSM state encodings (localparam constants)
//    - per-word pipeline operation codes
//    - Stokes component count and slot indices (slot 7 is the MS slot of a word)
//    - helpers for the end-of-integration decision
package xeng_vacc_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FIRST = 2'd1;
   localparam logic [1:0] ST_ACC   = 2'd2;
   localparam logic [1:0] ST_DUMP  = 2'd3;

   // Operation carried down the pipeline with each accepted word.
   localparam logic [1:0] OP_FIRST = 2'd0;  // write din, ignore BRAM
   localparam logic [1:0] OP_ACC   = 2'd1;  // write rd + din
   localparam logic [1:0] OP_DUMP  = 2'd2;  // output rd + din
   localparam logic [1:0] OP_BYP   = 2'd3;  // output din (integration of one vector)

   localparam int N_COMP    = 8;
   localparam int COMP_XX_R = 7;
   localparam int COMP_XX_I = 6;
   localparam int COMP_XY_R = 5;
   localparam int COMP_XY_I = 4;
   localparam int COMP_YX_R = 3;
   localparam int COMP_YX_I = 2;
   localparam int COMP_YY_R = 1;
   localparam int COMP_YY_I = 0;

   // True when the vector following a wrap (count next_cnt) is the last one
   // of an integration of len vectors. 33-bit math keeps len = 0 harmless.
   function automatic logic vec_is_last(input logic [31:0] next_cnt,
                                        input logic [31:0] len);
      return ({1'b0, next_cnt} + 33'd1) == {1'b0, len};
   endfunction

   // Integrations of 0 or 1 vectors never touch the BRAM.
   function automatic logic len_is_bypass(input logic [31:0] len);
      return len < 32'd2;
   endfunction

endpackage

// File: rtl/xeng_vacc_bram.sv
// xeng_vacc_bram
//    Simple dual-port RAM, one write port and one read port on clk_sys-style
//    single clock. Read data appears LATENCY cycles after the read address.
//    A read and write of the same address on the same edge returns old data.
//    Contents are not reset.
// Ports
//    clk    in   clock
//    we     in   write enable
//    waddr  in   write address
//    wdata  in   write data
//    raddr  in   read address (sampled every cycle)
//    rdata  out  read data, LATENCY cycles after raddr
module xeng_vacc_bram #(
   parameter int DATA_W  = 256,
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem     [2**ADDR_W];
   logic [DATA_W-1:0] rd_pipe [LATENCY];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rd_pipe[0] <= mem[raddr];
      for (int i = 1; i < LATENCY; i++) begin
         rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   assign rdata = rd_pipe[LATENCY-1];

endmodule

// File: rtl/xeng_vacc.sv
// xeng_vacc
//    Vector accumulator behind the X-engine. Sums acc_len successive vectors of
//    VEC_LEN words (8 signed Stokes components each) in BRAM by
//    read-modify-write and streams the finished sums, tagged with the mcnt of
//    the integration's first vector, during the last vector of each integration.
//
//    Optional feature macro: XENG_VACC_SAT_EN
//       defined   - overflowing components clamp to the signed ACC_W limits
//       undefined - overflowing components wrap (two's complement)
//       ovfl is set on overflow either way.
//
// Ports
//    clk         in   clock
//    rst_n       in   asynchronous reset, active low
//    sync_in     in   arms / restarts an integration; coincident word is word 0
//    din         in   8*IN_W   {xx_r,xx_i,xy_r,xy_i,yx_r,yx_i,yy_r,yy_i}
//    vld         in   din valid
//    window_vld  in   X-engine window valid, expected high whenever vld is
//    mcnt        in   timestamp of the current vector
//    acc_len     in   vectors per integration (sampled on sync_in and each dump)
//    clr_err     in   clears sticky flags (a same-cycle new error wins)
//    dout        out  8*ACC_W  accumulated word
//    dout_vld    out  dout valid, BRAM_LATENCY+2 cycles after the input word
//    dout_sync   out  high with word 0 of each dump
//    dout_addr   out  word index of dout
//    mcnt_out    out  mcnt of the dumped integration's first vector
//    ovfl        out  sticky component overflow
//    win_err     out  sticky vld-outside-window
//
// FSM
//    state    | meaning
//    ST_IDLE  | after reset; words ignored until sync_in
//    ST_FIRST | vector 0: write din (or bypass-dump when acc_len <= 1)
//    ST_ACC   | middle vectors: write rd + din
//    ST_DUMP  | last vector: emit rd + din, no write-back
module xeng_vacc
   import xeng_vacc_pkg::*;
#(
   parameter int IN_W         = 20,
   parameter int ACC_W        = 32,
   parameter int VEC_LEN      = 544,
   parameter int ADDR_W       = 10,
   parameter int BRAM_LATENCY = 2,
   parameter int MCNT_WIDTH   = 48
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sync_in,
   input  logic [8*IN_W-1:0]       din,
   input  logic                    vld,
   input  logic                    window_vld,
   input  logic [MCNT_WIDTH-1:0]   mcnt,
   input  logic [31:0]             acc_len,
   input  logic                    clr_err,
   output logic [8*ACC_W-1:0]      dout,
   output logic                    dout_vld,
   output logic                    dout_sync,
   output logic [ADDR_W-1:0]       dout_addr,
   output logic [MCNT_WIDTH-1:0]   mcnt_out,
   output logic                    ovfl,
   output logic                    win_err
);

   localparam int L      = BRAM_LATENCY;
   localparam int DIN_W  = N_COMP * IN_W;
   localparam int DOUT_W = N_COMP * ACC_W;

   logic [1:0]            state;
   logic [ADDR_W-1:0]     addr;
   logic [31:0]           vec_cnt;
   logic [31:0]           acc_len_q;
   logic [MCNT_WIDTH-1:0] mcnt_cap;

   logic [1:0]            eff_state;
   logic [ADDR_W-1:0]     eff_addr;
   logic [31:0]           eff_vcnt;
   logic [31:0]           eff_len;
   logic                  take;
   logic                  wrap;
   logic [1:0]            op;
   logic [MCNT_WIDTH-1:0] op_mcnt;

   // A sync_in takes effect on the word it arrives with, so the current word
   // is classified against the post-sync view of the control state.
   always_comb begin
      eff_state = sync_in ? ST_FIRST : state;
      eff_addr  = sync_in ? '0 : addr;
      eff_vcnt  = sync_in ? '0 : vec_cnt;
      eff_len   = sync_in ? acc_len : acc_len_q;
      take      = vld && (eff_state != ST_IDLE);
      wrap      = (eff_addr == ADDR_W'(VEC_LEN - 1));
      case (eff_state)
         ST_FIRST: op = len_is_bypass(eff_len) ? OP_BYP : OP_FIRST;
         ST_ACC:   op = OP_ACC;
         default:  op = OP_DUMP;
      endcase
      op_mcnt = (op == OP_BYP) ? mcnt : mcnt_cap;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr      <= '0;
         vec_cnt   <= '0;
         acc_len_q <= '0;
         mcnt_cap  <= '0;
      end else begin
         if (sync_in) begin
            state     <= ST_FIRST;
            addr      <= '0;
            vec_cnt   <= '0;
            acc_len_q <= acc_len;
         end
         if (take) begin
            if ((op == OP_FIRST) && (eff_addr == '0)) begin
               mcnt_cap <= mcnt;
            end
            if (!wrap) begin
               addr <= eff_addr + ADDR_W'(1);
            end else begin
               addr <= '0;
               case (op)
                  OP_FIRST, OP_ACC: begin
                     vec_cnt <= eff_vcnt + 32'd1;
                     state   <= vec_is_last(eff_vcnt + 32'd1, eff_len) ? ST_DUMP : ST_ACC;
                  end
                  default: begin
                     vec_cnt   <= '0;
                     state     <= ST_FIRST;
                     acc_len_q <= acc_len;
                  end
               endcase
            end
         end
      end
   end

   // Input side delayed to line up with BRAM read data.
   logic [L-1:0]          vld_d;
   logic [1:0]            op_d   [L];
   logic [ADDR_W-1:0]     addr_d [L];
   logic [DIN_W-1:0]      din_d  [L];
   logic [MCNT_WIDTH-1:0] mcnt_d [L];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < L; i++) begin
            vld_d[i]  <= 1'b0;
            op_d[i]   <= '0;
            addr_d[i] <= '0;
            din_d[i]  <= '0;
            mcnt_d[i] <= '0;
         end
      end else begin
         vld_d[0]  <= take;
         op_d[0]   <= op;
         addr_d[0] <= eff_addr;
         din_d[0]  <= din;
         mcnt_d[0] <= op_mcnt;
         for (int i = 1; i < L; i++) begin
            vld_d[i]  <= vld_d[i-1];
            op_d[i]   <= op_d[i-1];
            addr_d[i] <= addr_d[i-1];
            din_d[i]  <= din_d[i-1];
            mcnt_d[i] <= mcnt_d[i-1];
         end
      end
   end

   logic [DOUT_W-1:0]     rd_data;
   logic                  use_rd;
   logic [DIN_W-1:0]      din_p;
   logic [DOUT_W-1:0]     res_c;
   logic [N_COMP-1:0]     ovf_c;

   logic [DOUT_W-1:0]     res_q;
   logic                  ovf_q;
   logic                  vld_s;
   logic [1:0]            op_s;
   logic [ADDR_W-1:0]     addr_s;
   logic [MCNT_WIDTH-1:0] mcnt_s;
   logic                  wr_en;
   logic                  dump_s;

   assign use_rd = (op_d[L-1] == OP_ACC) || (op_d[L-1] == OP_DUMP);
   assign din_p  = din_d[L-1];

   for (genvar c = 0; c < N_COMP; c++) begin : g_comp
      logic [IN_W-1:0]  a_din;
      logic [ACC_W-1:0] a_rd;
      logic [ACC_W:0]   a_sum;

      assign a_din = din_p[c*IN_W +: IN_W];
      assign a_rd  = use_rd ? rd_data[c*ACC_W +: ACC_W] : '0;
      // One guard bit: overflow shows as the two top bits disagreeing.
      assign a_sum = {a_rd[ACC_W-1], a_rd}
                   + {{(ACC_W + 1 - IN_W){a_din[IN_W-1]}}, a_din};
      assign ovf_c[c] = a_sum[ACC_W] ^ a_sum[ACC_W-1];
`ifdef XENG_VACC_SAT_EN
      localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
      localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
      assign res_c[c*ACC_W +: ACC_W] = !ovf_c[c] ? a_sum[ACC_W-1:0]
                                     : (a_sum[ACC_W] ? SAT_MIN : SAT_MAX);
`else
      assign res_c[c*ACC_W +: ACC_W] = a_sum[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q  <= '0;
         ovf_q  <= 1'b0;
         vld_s  <= 1'b0;
         op_s   <= '0;
         addr_s <= '0;
         mcnt_s <= '0;
      end else begin
         res_q  <= res_c;
         ovf_q  <= vld_d[L-1] && (|ovf_c);
         vld_s  <= vld_d[L-1];
         op_s   <= op_d[L-1];
         addr_s <= addr_d[L-1];
         mcnt_s <= mcnt_d[L-1];
      end
   end

   assign wr_en  = vld_s && ((op_s == OP_FIRST) || (op_s == OP_ACC));
   assign dump_s = vld_s && ((op_s == OP_DUMP) || (op_s == OP_BYP));

   xeng_vacc_bram #(
      .DATA_W  (DOUT_W),
      .ADDR_W  (ADDR_W),
      .LATENCY (L)
   ) u_bram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (addr_s),
      .wdata (res_q),
      .raddr (eff_addr),
      .rdata (rd_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout      <= '0;
         dout_vld  <= 1'b0;
         dout_sync <= 1'b0;
         dout_addr <= '0;
         mcnt_out  <= '0;
         ovfl      <= 1'b0;
         win_err   <= 1'b0;
      end else begin
         dout_vld  <= dump_s;
         dout_sync <= dump_s && (addr_s == '0);
         if (dump_s) begin
            dout      <= res_q;
            dout_addr <= addr_s;
            if (addr_s == '0) begin
               mcnt_out <= mcnt_s;
            end
         end
         if (ovf_q) begin
            ovfl <= 1'b1;
         end else if (clr_err) begin
            ovfl <= 1'b0;
         end
         if (vld && !window_vld) begin
            win_err <= 1'b1;
         end else if (clr_err) begin
            win_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_xeng_vacc.sv
module tb_xeng_vacc;

   localparam int VEC  = 8;
   localparam int AW   = 3;
   localparam int BL   = 2;
   localparam int LAT  = BL + 2;
   localparam int INA  = 12;
   localparam int ACCA = 16;
   localparam int INB  = 8;
   localparam int ACCB = 8;
`ifdef XENG_VACC_SAT_EN
   localparam logic [7:0] EXP_B = 8'd127;
`else
   localparam logic [7:0] EXP_B = 8'd44;
`endif

   logic                 clk = 1'b0;
   logic                 rst_n, sync_in, vld, window_vld, clr_err;
   logic [8*INA-1:0]     din_a;
   logic [8*INB-1:0]     din_b;
   logic [47:0]          mcnt;
   logic [31:0]          acc_len;
   logic [8*ACCA-1:0]    dout_a;
   logic [8*ACCB-1:0]    dout_b;
   logic                 dout_vld_a, dout_sync_a, ovfl_a, win_err_a;
   logic                 dout_vld_b, dout_sync_b, ovfl_b, win_err_b;
   logic [AW-1:0]        dout_addr_a, dout_addr_b;
   logic [47:0]          mcnt_out_a, mcnt_out_b;

   xeng_vacc #(.IN_W(INA), .ACC_W(ACCA), .VEC_LEN(VEC), .ADDR_W(AW),
               .BRAM_LATENCY(BL), .MCNT_WIDTH(48)) dut_a (
      .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .din(din_a), .vld(vld),
      .window_vld(window_vld), .mcnt(mcnt), .acc_len(acc_len), .clr_err(clr_err),
      .dout(dout_a), .dout_vld(dout_vld_a), .dout_sync(dout_sync_a),
      .dout_addr(dout_addr_a), .mcnt_out(mcnt_out_a), .ovfl(ovfl_a), .win_err(win_err_a));

   xeng_vacc #(.IN_W(INB), .ACC_W(ACCB), .VEC_LEN(VEC), .ADDR_W(AW),
               .BRAM_LATENCY(BL), .MCNT_WIDTH(48)) dut_b (
      .clk(clk), .rst_n(rst_n), .sync_in(sync_in), .din(din_b), .vld(vld),
      .window_vld(window_vld), .mcnt(mcnt), .acc_len(acc_len), .clr_err(clr_err),
      .dout(dout_b), .dout_vld(dout_vld_b), .dout_sync(dout_sync_b),
      .dout_addr(dout_addr_b), .mcnt_out(mcnt_out_b), .ovfl(ovfl_b), .win_err(win_err_b));

   always #5 clk = ~clk;

   typedef struct {
      int           addr;
      logic         sync;
      logic [127:0] data;
      logic [47:0]  mcnt;
      int           cyc;
   } ent_t;

   ent_t        obs_q[$];
   ent_t        exp_q[$];
   logic [63:0] qb[$];
   ent_t        mon_e;
   int          cyc = 0;
   int          checks = 0;
   int          failures = 0;

   // Reference model: integration bookkeeping at vector level.
   int          m_acc[VEC][8];
   int          m_len;
   int          m_cnt;
   logic [47:0] m_mcnt;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (dout_vld_a) begin
         mon_e.addr = int'(dout_addr_a);
         mon_e.sync = dout_sync_a;
         mon_e.data = dout_a;
         mon_e.mcnt = mcnt_out_a;
         mon_e.cyc  = cyc;
         obs_q.push_back(mon_e);
      end
      if (dout_vld_b) qb.push_back(dout_b);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
      checks++;
      assert (obs === req) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   task automatic model_clear();
      for (int w = 0; w < VEC; w++)
         for (int c = 0; c < 8; c++) m_acc[w][c] = 0;
   endtask

   // mode 0: all components = cval; 1: random; 2: xx_r = cval, rest random.
   // nowin: word index sent with window_vld low and clr_err high (-1 none).
   task automatic send_vec(input int mode, input int cval, input bit do_sync,
                           input bit gaps, input logic [47:0] mc, input int nowin);
      bit last;
      int v;
      logic [8*INA-1:0] d;
      logic [127:0] e;
      ent_t x;
      if (do_sync) begin
         m_len = acc_len;
         m_cnt = 0;
         model_clear();
      end
      last = (m_cnt + 1 >= ((m_len < 1) ? 1 : m_len));
      for (int w = 0; w < VEC; w++) begin
         for (int c = 0; c < 8; c++) begin
            if (mode == 0 || (mode == 2 && c == 0)) v = cval;
            else v = int'($urandom_range(0, 2000)) - 1000;
            d[(7-c)*INA +: INA] = INA'(v);
            m_acc[w][c] += v;
            e[(7-c)*ACCA +: ACCA] = ACCA'(m_acc[w][c]);
         end
         if (w == 0 && m_cnt == 0) m_mcnt = mc;
         din_a = d;
         vld = 1'b1;
         sync_in = do_sync && (w == 0);
         mcnt = mc;
         window_vld = (w != nowin);
         clr_err = (w == nowin);
         if (last) begin
            x.addr = w; x.sync = (w == 0); x.data = e; x.mcnt = m_mcnt; x.cyc = cyc;
            exp_q.push_back(x);
         end
         step();
         vld = 1'b0; sync_in = 1'b0; window_vld = 1'b1; clr_err = 1'b0;
         if (gaps) repeat ($urandom_range(0, 2)) step();
      end
      m_cnt++;
      if (last) begin
         m_cnt = 0;
         model_clear();
         m_len = acc_len;
      end
   endtask

   task automatic compare_out(input string tag);
      int n;
      repeat (8) step();
      check({tag, "_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_addr"}, 128'(obs_q[i].addr), 128'(exp_q[i].addr));
         check({tag, "_sync"}, 128'(obs_q[i].sync), 128'(exp_q[i].sync));
         check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
         check({tag, "_mcnt"}, 128'(obs_q[i].mcnt), 128'(exp_q[i].mcnt));
         check({tag, "_latency"}, 128'(obs_q[i].cyc - exp_q[i].cyc), 128'(LAT));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   initial begin
      rst_n = 1'b0; sync_in = 1'b0; vld = 1'b0; window_vld = 1'b1; clr_err = 1'b0;
      din_a = '0; din_b = {8{8'd100}}; mcnt = '0; acc_len = 32'd4;
      m_len = 0; m_cnt = 0; m_mcnt = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check("rst_dout",      128'(dout_a),      128'(0));
      check("rst_dout_vld",  128'(dout_vld_a),  128'(0));
      check("rst_dout_sync", 128'(dout_sync_a), 128'(0));
      check("rst_dout_addr", 128'(dout_addr_a), 128'(0));
      check("rst_mcnt_out",  128'(mcnt_out_a),  128'(0));
      check("rst_ovfl",      128'(ovfl_a),      128'(0));
      check("rst_win_err",   128'(win_err_a),   128'(0));
      check("rst_b_dout_vld", 128'(dout_vld_b), 128'(0));
      rst_n = 1'b1;
      step();

      // 1: four vectors of +3 -> 12s, mcnt of vector 0
      acc_len = 32'd4;
      for (int v = 0; v < 4; v++) send_vec(0, 3, v == 0, 1'b0, 48'h1000 + 48'(v), -1);
      compare_out("t1");

      // 2: bypass integration, xx_r = -5 sign-extended
      acc_len = 32'd1;
      send_vec(2, -5, 1'b1, 1'b0, 48'hABCD_0001, -1);
      send_vec(2, -5, 1'b0, 1'b0, 48'hABCD_0002, -1);
      repeat (8) step();
      check("t2_xxr_sext", (obs_q.size() > 0) ? 128'(obs_q[0].data[127:112]) : 128'hx,
            128'(16'hFFFB));
      compare_out("t2");

      // 3: narrow accumulator overflow
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      obs_q.delete(); qb.delete();
      acc_len = 32'd3;
      for (int v = 0; v < 3; v++) send_vec(0, 100, v == 0, 1'b0, 48'h3000 + 48'(v), -1);
      compare_out("t3");
      check("t3_b_count", 128'(qb.size()), 128'(8));
      foreach (qb[i]) check("t3_b_data", 128'(qb[i]), 128'({8{EXP_B}}));
      check("t3_b_ovfl", 128'(ovfl_b), 128'(1));
      check("t3_a_ovfl", 128'(ovfl_a), 128'(0));

      // 4: sync after 2 of 4 vectors abandons the partial sums
      acc_len = 32'd4;
      send_vec(1, 0, 1'b1, 1'b0, 48'h4000, -1);
      send_vec(1, 0, 1'b0, 1'b0, 48'h4001, -1);
      for (int v = 0; v < 4; v++) send_vec(0, 1, v == 0, 1'b0, 48'h4100 + 48'(v), -1);
      compare_out("t4");

      // 5: random data with random vld gaps, two integrations of 2
      acc_len = 32'd2;
      for (int v = 0; v < 4; v++)
         send_vec(1, 0, v == 0, 1'b1, 48'(64'($urandom)) ^ 48'(v), -1);
      compare_out("t5");
      check("t5_ovfl", 128'(ovfl_a), 128'(0));

      // 6: vld outside window; clr_err in the same cycle loses to the error
      check("t6_win_err_pre", 128'(win_err_a), 128'(0));
      send_vec(1, 0, 1'b1, 1'b0, 48'h6000, 3);
      send_vec(1, 0, 1'b0, 1'b0, 48'h6001, -1);
      compare_out("t6");
      check("t6_win_err_set", 128'(win_err_a), 128'(1));
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      check("t6_win_err_clr", 128'(win_err_a), 128'(0));

      // reset in the middle of a dump
      acc_len = 32'd1;
      din_a = {8{12'h055}};
      mcnt = 48'h7000;
      vld = 1'b1; sync_in = 1'b1;
      step();
      sync_in = 1'b0;
      repeat (4) step();
      check("t6_dump_active", 128'(dout_vld_a), 128'(1));
      rst_n = 1'b0;
      #1;
      check("t6_rst_dout",      128'(dout_a),      128'(0));
      check("t6_rst_dout_vld",  128'(dout_vld_a),  128'(0));
      check("t6_rst_dout_sync", 128'(dout_sync_a), 128'(0));
      check("t6_rst_dout_addr", 128'(dout_addr_a), 128'(0));
      check("t6_rst_mcnt_out",  128'(mcnt_out_a),  128'(0));
      check("t6_rst_ovfl_b",    128'(ovfl_b),      128'(0));
      vld = 1'b0;
      #2;
      rst_n = 1'b1;
      step();
      obs_q.delete();
      vld = 1'b1;
      repeat (VEC) step();
      vld = 1'b0;
      repeat (8) step();
      check("t6_idle_after_rst", 128'(obs_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
